multicycle_core: RTL

- Parametrised multi-cycle RV32I-subset core; next generation of the single-cycle core.
- Shares one ALU and one memory port across instructions, sequenced by an FSM.
- Uses a single unified instruction/data memory interface with a req/ready handshake, so memory may take any number of cycles.
- Adds jal, bne, halt/trap reporting and a retire pulse for the bench and for a future performance counter.

---
 rtl/multicycle_core_if.sv | 30 +++
 rtl/multicycle_core.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_core_if.sv
// Unified instruction/data memory port of multicycle_core.
// Request fields are registered by the core and held until a cycle with mem_ready=1 completes them.
interface multicycle_core_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_core.sv
// Multi-cycle RV32I-subset core: one ALU and one memory port, sequenced by
// FETCH/DECODE/EXEC/MEM/WB/HALT, with retire pulse and halt cause reporting.
module multicycle_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NUM_REGS = 32,
  parameter int          ADDR_W   = 32
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_core_if.master   bus,
  output logic                retire,
  output logic [ADDR_W-1:0]   pc_out,
  output logic                halted,
  output logic [1:0]          halt_cause
);

  localparam int RIDX_W = $clog2(NUM_REGS);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_SYS = 7'b1110011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       ir_q, ir_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [31:0]       imm_q, imm_d;
  logic [31:0]       res_q, res_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic              halted_q, halted_d;
  logic [1:0]        cause_q, cause_d;
  logic [31:0]       rf_q [NUM_REGS];

  logic [6:0]  opcode_s;
  logic [4:0]  rd_s, rs1_s, rs2_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_j_s;
  logic [31:0] rs1_val_s, rs2_val_s;
  logic [31:0] alu_s, pc32_s, pc4_s, tgt_s;
  logic        r_funct_ok_s, legal_s, is_sys_s, taken_s, mem_done_s;
  logic        retire_s, rf_we_s;
  logic [31:0] rf_wdata_s;

  function automatic logic reg_ok(input logic [4:0] idx);
    return ({27'd0, idx} < 32'(NUM_REGS));
  endfunction

  assign opcode_s = ir_q[6:0];
  assign rd_s     = ir_q[11:7];
  assign funct3_s = ir_q[14:12];
  assign rs1_s    = ir_q[19:15];
  assign rs2_s    = ir_q[24:20];
  assign funct7_s = ir_q[31:25];

  assign imm_i_s = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b_s = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_j_s = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  // x0 is not stored meaningfully; it always reads as zero
  assign rs1_val_s = (rs1_s == 5'd0) ? 32'd0 : rf_q[rs1_s[RIDX_W-1:0]];
  assign rs2_val_s = (rs2_s == 5'd0) ? 32'd0 : rf_q[rs2_s[RIDX_W-1:0]];

  assign pc32_s     = 32'(pc_q);
  assign pc4_s      = pc32_s + 32'd4;
  assign tgt_s      = pc32_s + imm_q;
  assign taken_s    = funct3_s[0] ? (a_q != b_q) : (a_q == b_q);
  assign mem_done_s = mem_req_q && bus.mem_ready;

  assign r_funct_ok_s = ((funct7_s == 7'b0000000) &&
                         ((funct3_s == 3'b000) || (funct3_s == 3'b111) ||
                          (funct3_s == 3'b110) || (funct3_s == 3'b010))) ||
                        ((funct7_s == 7'b0100000) && (funct3_s == 3'b000));

  always_comb begin
    legal_s  = 1'b0;
    is_sys_s = 1'b0;
    case (opcode_s)
      OP_R:    legal_s = r_funct_ok_s && reg_ok(rd_s) && reg_ok(rs1_s) && reg_ok(rs2_s);
      OP_I:    legal_s = (funct3_s == 3'b000) && reg_ok(rd_s) && reg_ok(rs1_s);
      OP_LD:   legal_s = (funct3_s == 3'b010) && reg_ok(rd_s) && reg_ok(rs1_s);
      OP_ST:   legal_s = (funct3_s == 3'b010) && reg_ok(rs1_s) && reg_ok(rs2_s);
      OP_BR:   legal_s = ((funct3_s == 3'b000) || (funct3_s == 3'b001)) &&
                         reg_ok(rs1_s) && reg_ok(rs2_s);
      OP_JAL:  legal_s = reg_ok(rd_s);
      OP_SYS: begin
        legal_s  = (ir_q == 32'h0000_0073) || (ir_q == 32'h0010_0073);
        is_sys_s = legal_s;
      end
      default: legal_s = 1'b0;
    endcase
  end

  always_comb begin
    alu_s = a_q + imm_q;
    if (opcode_s == OP_R) begin
      case (funct3_s)
        3'b000:  alu_s = funct7_s[5] ? (a_q - b_q) : (a_q + b_q);
        3'b111:  alu_s = a_q & b_q;
        3'b110:  alu_s = a_q | b_q;
        3'b010:  alu_s = {31'd0, ($signed(a_q) < $signed(b_q))};
        default: alu_s = a_q + b_q;
      endcase
    end else begin
      alu_s = a_q + imm_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    imm_d       = imm_q;
    res_d       = res_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    halted_d    = halted_q;
    cause_d     = cause_q;
    retire_s    = 1'b0;
    rf_we_s     = 1'b0;
    rf_wdata_s  = res_q;
    case (state_q)
      S_FETCH: begin
        if (mem_done_s) begin
          ir_d      = bus.mem_rdata;
          mem_req_d = 1'b0;
          state_d   = S_DECODE;
        end else begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_q;
        end
      end
      S_DECODE: begin
        a_d = rs1_val_s;
        b_d = rs2_val_s;
        case (opcode_s)
          OP_ST:   imm_d = imm_s_s;
          OP_BR:   imm_d = imm_b_s;
          OP_JAL:  imm_d = imm_j_s;
          default: imm_d = imm_i_s;
        endcase
        if (!legal_s) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          cause_d  = 2'd2;
        end else if (is_sys_s) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
          cause_d  = 2'd1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (opcode_s)
          OP_R, OP_I: begin
            res_d   = alu_s;
            state_d = S_WB;
          end
          OP_LD, OP_ST: begin
            if (alu_s[1:0] != 2'b00) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
              cause_d  = 2'd3;
            end else begin
              mem_req_d   = 1'b1;
              mem_we_d    = (opcode_s == OP_ST);
              mem_addr_d  = ADDR_W'(alu_s);
              mem_wdata_d = (opcode_s == OP_ST) ? b_q : mem_wdata_q;
              state_d     = S_MEM;
            end
          end
          OP_BR: begin
            if (taken_s && (tgt_s[1:0] != 2'b00)) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
              cause_d  = 2'd3;
            end else begin
              // branch retires here; raise the next fetch right away
              retire_s   = 1'b1;
              pc_d       = taken_s ? ADDR_W'(tgt_s) : ADDR_W'(pc4_s);
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b0;
              mem_addr_d = pc_d;
              state_d    = S_FETCH;
            end
          end
          OP_JAL: begin
            if (tgt_s[1:0] != 2'b00) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
              cause_d  = 2'd3;
            end else begin
              res_d   = pc4_s;
              state_d = S_WB;
            end
          end
          default: begin
            state_d  = S_HALT;
            halted_d = 1'b1;
            cause_d  = 2'd2;
          end
        endcase
      end
      S_MEM: begin
        if (mem_done_s) begin
          mem_req_d = 1'b0;
          if (opcode_s == OP_ST) begin
            // request drops for a cycle; FETCH re-raises it
            retire_s = 1'b1;
            pc_d     = ADDR_W'(pc4_s);
            state_d  = S_FETCH;
          end else begin
            res_d   = bus.mem_rdata;
            state_d = S_WB;
          end
        end else begin
          mem_req_d = 1'b1;
        end
      end
      S_WB: begin
        rf_we_s    = (rd_s != 5'd0);
        retire_s   = 1'b1;
        pc_d       = (opcode_s == OP_JAL) ? ADDR_W'(tgt_s) : ADDR_W'(pc4_s);
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b0;
        mem_addr_d = pc_d;
        state_d    = S_FETCH;
      end
      S_HALT: begin
        mem_req_d = 1'b0;
        halted_d  = 1'b1;
      end
      default: begin
        state_d   = S_HALT;
        mem_req_d = 1'b0;
        halted_d  = 1'b1;
        cause_d   = 2'd2;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC[ADDR_W-1:0];
      ir_q        <= 32'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      imm_q       <= 32'd0;
      res_q       <= 32'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
      halted_q    <= 1'b0;
      cause_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      imm_q       <= imm_d;
      res_q       <= res_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      halted_q    <= halted_d;
      cause_q     <= cause_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= 32'd0;
      end
    end else if (rf_we_s) begin
      rf_q[rd_s[RIDX_W-1:0]] <= rf_wdata_s;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign retire        = retire_s;
  assign pc_out        = pc_q;
  assign halted        = halted_q;
  assign halt_cause    = cause_q;

endmodule
